ramp_down_adc_ctrl: RTL
=======================

Name: ramp_down_adc_ctrl

Overview:
- Sequential controller for a single-slope, down-counting ramp ADC.
- On `start`, drives the DAC code from `START_CODE` down by one LSB per step. After each step it waits a settle interval, then samples the analog comparator.
- Captures the first code at which the comparator trips and returns it to the consumer through a valid/ready handshake.
- It is the decrementing counterpart of the unprotected increment datapath and sits between the comparator front end and the digital result consumer.

Parameters:
- WIDTH, 8, width of the DAC code and of the result.
- START_CODE, {WIDTH{1'b1}}, first DAC code of every conversion.
- SETTLE_CYCLES, 1, DAC settle cycles per code before the comparator is sampled; legal range 0..15.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  conversion request; sampled in IDLE only.
- cmp  input  1  comparator output: 1 when Vin >= DAC level. It arrives already synchronized to clk.
- dac_code  output  WIDTH  code currently driven to the DAC.
- busy  output  1  high from the cycle after start is accepted until the handshake completes.
- result  output  WIDTH  captured conversion code.
- valid  output  1  result available.
- ready  input  1  consumer accepts the result when valid && ready.

Behaviour:
- Reset values (asynchronous on rst_n low): state=IDLE, dac_code=START_CODE, result=0, valid=0, busy=0, settle counter=0.
- A reset asserted mid-conversion aborts it immediately. No partial result is emitted.
- States: IDLE, SETTLE, COMPARE, DONE.
- IDLE:
  - start=1 -> dac_code<=START_CODE, settle counter<=SETTLE_CYCLES, busy<=1.
  - Next state is SETTLE, or COMPARE directly if SETTLE_CYCLES==0.
- SETTLE:
  - Counter decrements each cycle.
  - Move to COMPARE on the edge where the counter equals 1.
  - Exactly SETTLE_CYCLES cycles are spent in SETTLE.
- COMPARE (one cycle), in priority order:
  - cmp=1 -> result<=dac_code, valid<=1, go to DONE.
  - Else, if dac_code==0 -> result<=0, valid<=1, go to DONE. No wrap to all-ones (floor saturation).
  - Else -> dac_code<=dac_code-1, reload the settle counter, go to SETTLE (or stay in COMPARE if SETTLE_CYCLES==0).
- Decrement datapath:
  - Ripple borrow chain over WIDTH bits, LSB borrow-in = 1.
  - Result is modulo 2^WIDTH, but the 0 case is never reached because of the floor check above.
- DONE:
  - valid stays 1; result and dac_code are held stable.
  - start is ignored.
  - valid && ready -> valid<=0, busy<=0, go to IDLE.
  - start asserted in the same cycle as the handshake is not accepted; it must be re-asserted while in IDLE.
- dac_code holds its final value through DONE and IDLE until the next accepted start.
- Latency:
  - Let trip code K be the first code with cmp=1 in COMPARE.
  - valid rises (START_CODE-K+1)*(SETTLE_CYCLES+1) cycles after the start-accept edge.
  - Floor case: (START_CODE+1)*(SETTLE_CYCLES+1) cycles, result=0.
- cmp is ignored outside COMPARE.
- ready is ignored outside DONE.

Test Plan:
- Reset check: hold rst_n=0 with random start, cmp and ready -> dac_code=0xFF, result=0x00, valid=0, busy=0. Then release rst_n with start=0 -> outputs unchanged.
- Trip mid-scale: SETTLE_CYCLES=1, cmp=(dac_code<=0x80) modelled one cycle after the code change, ready=1 -> result=0x80, valid rises 256 cycles after start accept. dac_code must pass through 0x90->0x8F and 0x81->0x80 with no skipped codes.
- Immediate trip: cmp=1 constantly -> result=0xFF, valid after SETTLE_CYCLES+1=2 cycles, dac_code never decrements.
- Floor: cmp=0 constantly -> dac_code reaches 0x00 and stays there (no 0xFF wrap), result=0x00, valid after 512 cycles.
- Backpressure: reach DONE with result=0x3C, ready=0 for 10 cycles while start pulses -> valid=1, result=0x3C and busy=1 stay stable and start is ignored. Then ready=1 for one cycle -> valid=0, busy=0 next edge. A start in that same cycle is not accepted; a later start begins a new conversion from 0xFF.
- Reset mid-conversion: assert rst_n=0 asynchronously while dac_code=0x40 in SETTLE -> immediate reset values, no valid pulse. After release, start -> full conversion from 0xFF with the correct result.

Source files
------------

// File: rtl/ramp_down_adc_ctrl.sv
// ramp_down_adc_ctrl: single-slope down-counting ramp ADC sequencer with valid/ready result handoff
module ramp_down_adc_ctrl #(
  parameter int               WIDTH         = 8,
  parameter logic [WIDTH-1:0] START_CODE    = {WIDTH{1'b1}},
  parameter int               SETTLE_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             cmp,
  output logic [WIDTH-1:0] dac_code,
  output logic             busy,
  output logic [WIDTH-1:0] result,
  output logic             valid,
  input  logic             ready
);
  typedef enum logic [1:0] {IDLE, SETTLE, COMPARE, DONE} state_e;
  localparam logic [3:0] SETTLE_INIT = 4'(SETTLE_CYCLES);
  localparam state_e AFTER_STEP = (SETTLE_CYCLES == 0) ? COMPARE : SETTLE;
  state_e           state_q;
  logic [WIDTH-1:0] dac_q, res_q, dec_d, borrow;
  logic [3:0]       cnt_q;
  logic             valid_q, busy_q;
  assign borrow[0] = 1'b1;
  for (genvar i = 0; i < WIDTH; i++) begin : g_dec
    assign dec_d[i] = dac_q[i] ^ borrow[i];
    if (i < WIDTH - 1) begin : g_borrow
      assign borrow[i+1] = ~dac_q[i] & borrow[i];
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      dac_q   <= START_CODE;
      res_q   <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          dac_q   <= START_CODE;
          cnt_q   <= SETTLE_INIT;
          busy_q  <= 1'b1;
          state_q <= AFTER_STEP;
        end
        SETTLE: begin
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q == 4'd1) state_q <= COMPARE;
        end
        COMPARE: if (cmp) begin
          res_q   <= dac_q;
          valid_q <= 1'b1;
          state_q <= DONE;
        end else if (dac_q == '0) begin
          // floor saturation: report zero rather than wrapping to all-ones
          res_q   <= '0;
          valid_q <= 1'b1;
          state_q <= DONE;
        end else begin
          dac_q   <= dec_d;
          cnt_q   <= SETTLE_INIT;
          state_q <= AFTER_STEP;
        end
        DONE: if (ready) begin
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign dac_code = dac_q;
  assign result   = res_q;
  assign valid    = valid_q;
  assign busy     = busy_q;
endmodule
